sig_slice_gatherer: RTL and testbench
=====================================

Name: sig_slice_gatherer

Overview:
- Sequences the two producers that drive the shared 224-bit bus SIG_NAMEA. Upper slice [223:128] comes from port A; lower slice [127:0] comes from port B.
- Each slice is captured independently under a valid/ready handshake.
- The full word is presented downstream only once both halves are held.
- Producers are back-pressured until the assembled word drains. This prevents mixed-generation words on SIG_NAMEA.

Parameters:
- HI_W, 96, width of the upper slice (port A).
- LO_W, 128, width of the lower slice (port B).
- SEQ_W, 8, width of the emitted-word sequence counter.
- TMO_CYC, 64, partial-word timeout in cycles. Used only with SLICE_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_l  in  1  synchronous reset, active-low.
- a_valid  in  1  upper slice offered.
- a_data  in  HI_W  upper slice data.
- a_ready  out  1  upper slice accepted this cycle when a_valid=1.
- b_valid  in  1  lower slice offered.
- b_data  in  LO_W  lower slice data.
- b_ready  out  1  lower slice accepted this cycle when b_valid=1.
- SIG_NAMEA  out  HI_W+LO_W  assembled word, {hi,lo}.
- out_valid  out  1  SIG_NAMEA holds a complete word.
- out_ready  in  1  consumer accepts the word.
- out_seq  out  SEQ_W  count of words emitted; wraps modulo 2^SEQ_W.
- tmo_err  out  1  sticky timeout flag. Exists only with SLICE_TIMEOUT_EN.

Behaviour:
- Reset (reset_l=0 at a clk edge):
  - state=EMPTY.
  - SIG_NAMEA=0, out_valid=0, out_seq=0, tmo_err=0.
  - a_ready=0 and b_ready=0 while reset_l=0.
- States: EMPTY, HAVE_A, HAVE_B, FULL. Encoding comes from the package.
- Drain event:
  - drain = out_valid & out_ready.
  - out_valid = (state==FULL). It is registered.
- Ready rules (combinational):
  - a_ready = reset_l & (state∈{EMPTY,HAVE_B} | drain).
  - b_ready = reset_l & (state∈{EMPTY,HAVE_A} | drain).
- Capture and transitions:
  - A capture writes SIG_NAMEA[HI_W+LO_W-1:LO_W]; B capture writes SIG_NAMEA[LO_W-1:0]. Latency from accept to visible data is 1 cycle.
  - EMPTY: A only -> HAVE_A; B only -> HAVE_B; both in the same cycle -> FULL.
  - HAVE_A: B -> FULL. A is not accepted again.
  - HAVE_B: A -> FULL. B is not accepted again.
  - FULL without drain: hold. Data must remain stable while out_valid=1.
  - FULL with drain: out_seq increments. Next state follows same-cycle captures: none -> EMPTY; A -> HAVE_A; B -> HAVE_B; both -> FULL. This gives back-to-back words at full throughput.
- Unaccepted slices: SIG_NAMEA bits for a slice not yet captured keep stale values. Consumers must qualify with out_valid.
- out_seq wraps from 2^SEQ_W-1 to 0.
- Reset mid-operation: partial and full words are discarded without a drain, and out_seq clears.

Optional Feature:
- Macro: SLICE_TIMEOUT_EN.
- Defined:
  - A counter runs while state∈{HAVE_A,HAVE_B} and clears on any other state.
  - When it reaches TMO_CYC-1, the next state is EMPTY, the partial word is dropped, and tmo_err is set sticky (cleared only by reset).
  - If the missing slice arrives in that same cycle, the capture wins: FULL, no error.
- Undefined: no counter and no tmo_err port. Partial words wait indefinitely.

Decomposition:
- Package sig_slice_pkg:
  - state typedef (EMPTY/HAVE_A/HAVE_B/FULL, 2-bit).
  - default width constants HI_W_D=96, LO_W_D=128.
- Sub-module sig_slice_hold: a parameterised width-W capture register with load enable. Instantiated twice, for the hi and lo slices. The FSM, ready logic, seq counter and timeout stay in the top.

Test Plan:
- A=0xAAA…(96b) at cycle 2, B=0x555…(128b) at cycle 5, out_ready=1 -> out_valid=1 at cycle 6, SIG_NAMEA={A,B}, out_seq 0->1 at cycle 7.
- A and B both valid in the same cycle from EMPTY, out_ready=0 for 10 cycles -> FULL held with a_ready=b_ready=0 and data stable. Release -> one drain, then EMPTY.
- Continuous a_valid=b_valid=out_ready=1 for 300 words -> one word per cycle after the first, and out_seq wraps 255->0 exactly once.
- HAVE_A, then reset_l=0 for 1 cycle, then B only -> state HAVE_B, out_valid=0, out_seq=0.
- With SLICE_TIMEOUT_EN and TMO_CYC=64: A only, B withheld -> after 64 cycles state=EMPTY and tmo_err=1. Then A+B -> normal word emitted, tmo_err stays 1.
- With SLICE_TIMEOUT_EN: B arrives in the timeout cycle -> FULL, tmo_err=0.

Source files
------------

// File: rtl/sig_slice_pkg.sv
// -----------------------------------------------------------------------------
// sig_slice_pkg
//   Shared definitions for the SIG_NAMEA slice gatherer.
//   - default slice widths (upper slice from port A, lower slice from port B)
//   - 2-bit FSM state type and its encoding
//   - helpers mapping between "which halves are held" and the state code
//
// The encoding is chosen so that bit 0 means "upper slice held" and bit 1
// means "lower slice held"; FULL is simply both bits set.
// -----------------------------------------------------------------------------
package sig_slice_pkg;

  localparam int HI_W_D = 96;
  localparam int LO_W_D = 128;

  typedef logic [1:0] slice_state_t;

  localparam slice_state_t ST_EMPTY  = 2'b00;
  localparam slice_state_t ST_HAVE_A = 2'b01;
  localparam slice_state_t ST_HAVE_B = 2'b10;
  localparam slice_state_t ST_FULL   = 2'b11;

  // Build the state code from the held-half flags.
  function automatic slice_state_t state_from_halves(input logic have_hi,
                                                     input logic have_lo);
    slice_state_t s;
    s = {have_lo, have_hi};
    return s;
  endfunction

  // True when the state already holds the upper slice.
  function automatic logic holds_hi(input slice_state_t s);
    return (s == ST_HAVE_A) || (s == ST_FULL);
  endfunction

  // True when the state already holds the lower slice.
  function automatic logic holds_lo(input slice_state_t s);
    return (s == ST_HAVE_B) || (s == ST_FULL);
  endfunction

endpackage

// File: rtl/sig_slice_hold.sv
// -----------------------------------------------------------------------------
// sig_slice_hold
//   Width-W capture register with load enable. One instance holds each slice
//   of the assembled word. Contents change only when load is asserted, so the
//   slice stays stable for as long as the gatherer keeps load low.
//
// Ports
//   clk      in   clock, rising edge
//   reset_l  in   synchronous reset, active-low; clears the register
//   load     in   capture d on this edge
//   d        in   W  slice data to capture
//   q        out  W  held slice
// -----------------------------------------------------------------------------
module sig_slice_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sig_slice_gatherer.sv
// -----------------------------------------------------------------------------
// sig_slice_gatherer
//   Assembles the shared bus SIG_NAMEA from two independent producers:
//   upper slice [HI_W+LO_W-1:LO_W] from port A, lower slice [LO_W-1:0] from
//   port B. Each slice is taken under its own valid/ready handshake; the word
//   is presented downstream only once both halves are held, and producers are
//   back-pressured until it drains so a word never mixes generations.
//
//   State | meaning
//   ------+-------------------------------------------------------------
//   EMPTY | no slice held; both producers may deliver
//   HAVE_A| upper slice held, waiting for lower
//   HAVE_B| lower slice held, waiting for upper
//   FULL  | complete word on SIG_NAMEA, out_valid=1, waiting for drain
//
// Ports
//   clk        in   clock, rising edge
//   reset_l    in   synchronous reset, active-low
//   a_valid    in   upper slice offered
//   a_data     in   HI_W upper slice data
//   a_ready    out  upper slice accepted this cycle when a_valid=1
//   b_valid    in   lower slice offered
//   b_data     in   LO_W lower slice data
//   b_ready    out  lower slice accepted this cycle when b_valid=1
//   SIG_NAMEA  out  HI_W+LO_W assembled word {hi,lo}
//   out_valid  out  SIG_NAMEA holds a complete word
//   out_ready  in   consumer accepts the word
//   out_seq    out  SEQ_W count of words emitted, wraps
//   tmo_err    out  sticky partial-word timeout (only with SLICE_TIMEOUT_EN)
//
// Build option
//   SLICE_TIMEOUT_EN : when defined, a partial word held for TMO_CYC cycles
//   is dropped and tmo_err is set. When undefined, partial words wait forever
//   and neither the TMO_CYC parameter nor the tmo_err port exist.
// -----------------------------------------------------------------------------
module sig_slice_gatherer
  import sig_slice_pkg::*;
#(
  parameter int HI_W  = HI_W_D,
  parameter int LO_W  = LO_W_D,
  parameter int SEQ_W = 8
`ifdef SLICE_TIMEOUT_EN
  , parameter int TMO_CYC = 64
`endif
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 a_valid,
  input  logic [HI_W-1:0]      a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [LO_W-1:0]      b_data,
  output logic                 b_ready,
  output logic [HI_W+LO_W-1:0] SIG_NAMEA,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEQ_W-1:0]     out_seq
`ifdef SLICE_TIMEOUT_EN
  , output logic               tmo_err
`endif
);

  slice_state_t    state_q;
  slice_state_t    state_d;
  logic            drain;
  logic            a_fire;
  logic            b_fire;
  logic            hi_next;
  logic            lo_next;
  logic [HI_W-1:0] hi_q;
  logic [LO_W-1:0] lo_q;

  assign drain = out_valid & out_ready;

  // Readiness is gated by reset_l so no slice is ever accepted during reset.
  assign a_ready = reset_l & ((state_q == ST_EMPTY) || (state_q == ST_HAVE_B) || drain);
  assign b_ready = reset_l & ((state_q == ST_EMPTY) || (state_q == ST_HAVE_A) || drain);

  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;

  // A half is held next cycle if it is held now and not leaving with a drain,
  // or if it is captured now. This one rule covers every transition,
  // including drain-and-refill in the same cycle for back-to-back words.
  assign hi_next = (holds_hi(state_q) & ~drain) | a_fire;
  assign lo_next = (holds_lo(state_q) & ~drain) | b_fire;

`ifdef SLICE_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

  logic             partial;
  logic             tmo_hit;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;

  assign partial = (state_q == ST_HAVE_A) || (state_q == ST_HAVE_B);

  // Down-counter is preloaded whenever no partial word is held, so it reads
  // TMO_CYC-1 on the first partial cycle and hits zero on the TMO_CYC-th.
  // A capture that completes the word in that cycle takes priority.
  assign tmo_hit = partial & (tmo_cnt_q == '0) & ~(hi_next & lo_next);

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      tmo_cnt_q <= TMO_LOAD;
      tmo_err_q <= 1'b0;
    end else begin
      if (partial) begin
        tmo_cnt_q <= tmo_cnt_q - TMO_W'(1);
      end else begin
        tmo_cnt_q <= TMO_LOAD;
      end
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
      end
    end
  end

  assign tmo_err = tmo_err_q;
`endif

  always_comb begin
    state_d = state_from_halves(hi_next, lo_next);
`ifdef SLICE_TIMEOUT_EN
    if (tmo_hit) begin
      state_d = ST_EMPTY;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q   <= ST_EMPTY;
      out_valid <= 1'b0;
      out_seq   <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == ST_FULL);
      if (drain) begin
        out_seq <= out_seq + SEQ_W'(1);
      end
    end
  end

  // Dropped or not-yet-captured slices keep stale contents; consumers
  // qualify SIG_NAMEA with out_valid.
  sig_slice_hold #(.W(HI_W)) u_hold_hi (
    .clk     (clk),
    .reset_l (reset_l),
    .load    (a_fire),
    .d       (a_data),
    .q       (hi_q)
  );

  sig_slice_hold #(.W(LO_W)) u_hold_lo (
    .clk     (clk),
    .reset_l (reset_l),
    .load    (b_fire),
    .d       (b_data),
    .q       (lo_q)
  );

  assign SIG_NAMEA = {hi_q, lo_q};

endmodule

// File: tb/tb_sig_slice_gatherer.sv
module tb_sig_slice_gatherer;

  localparam int HI_W  = 96;
  localparam int LO_W  = 128;
  localparam int SEQ_W = 8;
`ifdef SLICE_TIMEOUT_EN
  localparam int TMO = 64;
`endif

  logic                 clk = 1'b0;
  logic                 reset_l;
  logic                 a_valid;
  logic [HI_W-1:0]      a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [LO_W-1:0]      b_data;
  logic                 b_ready;
  logic [HI_W+LO_W-1:0] SIG_NAMEA;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEQ_W-1:0]     out_seq;
`ifdef SLICE_TIMEOUT_EN
  logic                 tmo_err;
`endif

  always #5 clk = ~clk;

  sig_slice_gatherer #(
    .HI_W  (HI_W),
    .LO_W  (LO_W),
    .SEQ_W (SEQ_W)
`ifdef SLICE_TIMEOUT_EN
    , .TMO_CYC (TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .SIG_NAMEA (SIG_NAMEA),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seq   (out_seq)
`ifdef SLICE_TIMEOUT_EN
    , .tmo_err (tmo_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural reference: which halves are held, their data, and counters.
  bit              m_a, m_b;
  logic [HI_W-1:0] m_hi;
  logic [LO_W-1:0] m_lo;
  int              m_seq;
`ifdef SLICE_TIMEOUT_EN
  bit              m_tmo;
  int              m_wait;
`endif

  logic [HI_W-1:0] A_PAT;
  logic [LO_W-1:0] B_PAT;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ar();
    return reset_l && (!m_a || (m_a && m_b && out_ready));
  endfunction

  function automatic bit exp_br();
    return reset_l && (!m_b || (m_a && m_b && out_ready));
  endfunction

  function automatic logic [HI_W-1:0] rnd_hi();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LO_W-1:0] rnd_lo();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_check();
    chk("a_ready", 256'(a_ready), 256'(exp_ar()));
    chk("b_ready", 256'(b_ready), 256'(exp_br()));
    chk("out_valid", 256'(out_valid), 256'(m_a && m_b));
    chk("out_seq", 256'(out_seq), 256'(m_seq % 256));
    chk("SIG_NAMEA", 256'(SIG_NAMEA), 256'({m_hi, m_lo}));
`ifdef SLICE_TIMEOUT_EN
    chk("tmo_err", 256'(tmo_err), 256'(m_tmo));
`endif
  endtask

  // Apply inputs for one cycle, let them settle, compare against the model.
  task automatic apply(input bit rl, input bit av, input logic [HI_W-1:0] ad,
                       input bit bv, input logic [LO_W-1:0] bd, input bit ordy);
    reset_l   = rl;
    a_valid   = av;
    a_data    = ad;
    b_valid   = bv;
    b_data    = bd;
    out_ready = ordy;
    #1;
    model_check();
  endtask

  // Advance the model by the edge that is about to happen, then the clock.
  task automatic tick();
    bit af, bf, drain, was_partial;
    af = a_valid && exp_ar();
    bf = b_valid && exp_br();
    if (!reset_l) begin
      m_a = 0; m_b = 0; m_hi = '0; m_lo = '0; m_seq = 0;
`ifdef SLICE_TIMEOUT_EN
      m_tmo = 0; m_wait = 0;
`endif
    end else begin
      drain       = m_a && m_b && out_ready;
      was_partial = m_a ^ m_b;
      if (drain) begin
        m_seq = (m_seq + 1) % 256;
        m_a = 0;
        m_b = 0;
      end
      if (af) begin m_a = 1; m_hi = a_data; end
      if (bf) begin m_b = 1; m_lo = b_data; end
`ifdef SLICE_TIMEOUT_EN
      if (was_partial && !(m_a && m_b)) begin
        if (m_wait == TMO - 1) begin
          m_a = 0; m_b = 0; m_tmo = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        m_wait = 0;
      end
`else
      was_partial = was_partial;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         rl, av, bv, ordy;
    bit         e_ar, e_br, e_ov;
    logic [7:0] e_seq;
    bit         e_dat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    A_PAT = {24{4'hA}};
    B_PAT = {32{4'h5}};
    m_a = 0; m_b = 0; m_hi = '0; m_lo = '0; m_seq = 0;
`ifdef SLICE_TIMEOUT_EN
    m_tmo = 0; m_wait = 0;
`endif
    reset_l = 0; a_valid = 0; b_valid = 0; out_ready = 0;
    a_data = '0; b_data = '0;
    @(posedge clk);
    #1;

    //             rl av bv or  ar br ov seq dat
    tbl[0]  = '{0, 0, 0, 0,  0, 0, 0, 8'd0, 0};
    tbl[1]  = '{1, 0, 0, 0,  1, 1, 0, 8'd0, 0};
    tbl[2]  = '{1, 1, 0, 0,  1, 1, 0, 8'd0, 0};
    tbl[3]  = '{1, 0, 0, 1,  0, 1, 0, 8'd0, 0};
    tbl[4]  = '{1, 0, 0, 0,  0, 1, 0, 8'd0, 0};
    tbl[5]  = '{1, 0, 1, 1,  0, 1, 0, 8'd0, 0};
    tbl[6]  = '{1, 0, 0, 1,  1, 1, 1, 8'd0, 1};
    tbl[7]  = '{1, 0, 0, 0,  1, 1, 0, 8'd1, 0};
    tbl[8]  = '{1, 1, 0, 0,  1, 1, 0, 8'd1, 0};
    tbl[9]  = '{0, 0, 0, 0,  0, 0, 0, 8'd1, 0};
    tbl[10] = '{1, 0, 1, 0,  1, 1, 0, 8'd0, 0};
    tbl[11] = '{1, 0, 0, 0,  1, 0, 0, 8'd0, 0};
    tbl[12] = '{1, 1, 1, 0,  1, 0, 0, 8'd0, 0};
    tbl[13] = '{1, 1, 1, 0,  0, 0, 1, 8'd0, 1};
    tbl[14] = '{1, 1, 1, 1,  1, 1, 1, 8'd0, 1};
    tbl[15] = '{1, 0, 1, 1,  1, 1, 1, 8'd1, 1};
    tbl[16] = '{1, 0, 0, 0,  1, 0, 0, 8'd2, 0};

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].rl, tbl[i].av, tbl[i].av ? A_PAT : '0,
            tbl[i].bv, tbl[i].bv ? B_PAT : '0, tbl[i].ordy);
      chk($sformatf("tbl%0d.a_ready", i), 256'(a_ready), 256'(tbl[i].e_ar));
      chk($sformatf("tbl%0d.b_ready", i), 256'(b_ready), 256'(tbl[i].e_br));
      chk($sformatf("tbl%0d.out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.out_seq", i), 256'(out_seq), 256'(tbl[i].e_seq));
      if (tbl[i].e_dat)
        chk($sformatf("tbl%0d.word", i), 256'(SIG_NAMEA), 256'({A_PAT, B_PAT}));
      tick();
    end

    // Both halves at once from EMPTY, then held under back-pressure.
    begin
      logic [HI_W-1:0] ph;
      logic [LO_W-1:0] pl;
      apply(0, 0, '0, 0, '0, 0);
      tick();
      ph = rnd_hi();
      pl = rnd_lo();
      apply(1, 1, ph, 1, pl, 0);
      tick();
      for (int k = 0; k < 10; k++) begin
        apply(1, 1, rnd_hi(), 1, rnd_lo(), 0);
        chk("hold.a_ready", 256'(a_ready), 256'(0));
        chk("hold.b_ready", 256'(b_ready), 256'(0));
        chk("hold.out_valid", 256'(out_valid), 256'(1));
        chk("hold.word", 256'(SIG_NAMEA), 256'({ph, pl}));
        tick();
      end
      apply(1, 0, '0, 0, '0, 1);
      chk("release.out_valid", 256'(out_valid), 256'(1));
      tick();
      apply(1, 0, '0, 0, '0, 1);
      chk("after_drain.out_valid", 256'(out_valid), 256'(0));
      chk("after_drain.out_seq", 256'(out_seq), 256'(1));
      chk("after_drain.a_ready", 256'(a_ready), 256'(1));
      tick();
    end

    // Full throughput: 300 words back to back, out_seq wraps exactly once.
    begin
      int ov_cnt, wraps;
      logic [SEQ_W-1:0] prev;
      ov_cnt = 0;
      wraps  = 0;
      apply(0, 0, '0, 0, '0, 0);
      tick();
      prev = 8'd0;
      for (int i = 0; i <= 300; i++) begin
        apply(1, 1, rnd_hi(), 1, rnd_lo(), 1);
        if (i >= 1 && out_valid === 1'b1) ov_cnt++;
        if (prev == 8'd255 && out_seq == 8'd0) wraps++;
        prev = out_seq;
        tick();
      end
      apply(1, 0, '0, 0, '0, 0);
      if (prev == 8'd255 && out_seq == 8'd0) wraps++;
      chk("stream.words", 256'(ov_cnt), 256'(300));
      chk("stream.wraps", 256'(wraps), 256'(1));
      chk("stream.final_seq", 256'(out_seq), 256'(300 % 256));
      tick();
    end

`ifdef SLICE_TIMEOUT_EN
    // Partial word abandoned: dropped after TMO cycles, error sticks.
    apply(0, 0, '0, 0, '0, 0);
    tick();
    apply(1, 1, A_PAT, 0, '0, 0);
    tick();
    for (int k = 1; k <= TMO; k++) begin
      apply(1, 0, '0, 0, '0, 0);
      if (k == TMO) begin
        chk("tmo.last_wait.a_ready", 256'(a_ready), 256'(0));
        chk("tmo.last_wait.err", 256'(tmo_err), 256'(0));
      end
      tick();
    end
    apply(1, 0, '0, 0, '0, 0);
    chk("tmo.dropped.a_ready", 256'(a_ready), 256'(1));
    chk("tmo.dropped.err", 256'(tmo_err), 256'(1));
    tick();
    apply(1, 1, A_PAT, 1, B_PAT, 0);
    tick();
    apply(1, 0, '0, 0, '0, 1);
    chk("tmo.word.out_valid", 256'(out_valid), 256'(1));
    chk("tmo.word.err", 256'(tmo_err), 256'(1));
    tick();

    // Missing half arrives in the timeout cycle: capture wins.
    apply(0, 0, '0, 0, '0, 0);
    tick();
    apply(1, 1, A_PAT, 0, '0, 0);
    tick();
    for (int k = 1; k < TMO; k++) begin
      apply(1, 0, '0, 0, '0, 0);
      tick();
    end
    apply(1, 0, '0, 1, B_PAT, 0);
    chk("tmo_race.b_ready", 256'(b_ready), 256'(1));
    tick();
    apply(1, 0, '0, 0, '0, 0);
    chk("tmo_race.out_valid", 256'(out_valid), 256'(1));
    chk("tmo_race.err", 256'(tmo_err), 256'(0));
    tick();
`endif

    // Randomised traffic against the reference model, with occasional resets
    // and stretches where port B goes quiet so partial words linger.
    for (int i = 0; i < 3000; i++) begin
      bit rl, av, bv, ordy;
      int seg;
      seg  = i / 250;
      rl   = ($urandom_range(0, 99) != 0);
      av   = ($urandom_range(0, 9) < 6);
      bv   = (seg % 4 == 3) ? 1'b0 : ($urandom_range(0, 9) < 5);
      ordy = ($urandom_range(0, 9) < 7);
      apply(rl, av, rnd_hi(), bv, rnd_lo(), ordy);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
